// File: rtl/ground_detect.sv
// ground_detect: once per frame, scans a platform ROM and reports the surface the character's feet rest on
// Ports:
//   i_clk, i_rst (async, active-low)   clock and reset
//   i_frame_tick                       one-cycle pulse per frame; starts a scan when idle
//   i_pos_x, i_pos_y                   character top-left position, snapshotted at scan start
//   o_plat_addr                        platform ROM address
//   i_plat_x, i_plat_y, i_plat_w       platform entry, valid one cycle after its address (w=0: disabled)
//   o_on_ground, o_ground_y            registered result, updated only at scan end
//   o_scan_busy, o_scan_done           scan in progress / one-cycle result-update pulse
module ground_detect #(
    parameter int NUM_PLAT = 8,
    parameter int CHAR_W   = 32,
    parameter int CHAR_H   = 48,
    parameter int FLOOR_Y  = 700,
    parameter int SNAP_TOL = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_frame_tick,
    input  logic [11:0]                 i_pos_x,
    input  logic [11:0]                 i_pos_y,
    output logic [$clog2(NUM_PLAT)-1:0] o_plat_addr,
    input  logic [11:0]                 i_plat_x,
    input  logic [11:0]                 i_plat_y,
    input  logic [11:0]                 i_plat_w,
    output logic                        o_on_ground,
    output logic [11:0]                 o_ground_y,
    output logic                        o_scan_busy,
    output logic                        o_scan_done
);
    localparam int AW = $clog2(NUM_PLAT);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_PLAT);
    localparam logic [11:0] FLOOR = 12'(FLOOR_Y);
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
    state_t      r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [11:0] r_px, r_best, w_nbest;
    logic [12:0] r_feet, w_px, w_plx, w_ply;
    logic        r_valid, w_eval, w_last, w_hit, w_take, w_nvalid, w_floor;
    // r_cnt counts SCAN cycles: addresses go out while r_cnt < NUM_PLAT,
    // and entry r_cnt-1 is evaluated while r_cnt >= 1
    assign w_eval   = (r_state == SCAN) && (r_cnt != '0);
    assign w_last   = (r_state == SCAN) && (r_cnt == LAST);
    assign w_px     = {1'b0, r_px};
    assign w_plx    = {1'b0, i_plat_x};
    assign w_ply    = {1'b0, i_plat_y};
    assign w_hit    = w_eval && (i_plat_w != '0)
                      && (w_px + 13'(CHAR_W) > w_plx)
                      && (w_px < w_plx + {1'b0, i_plat_w})
                      && (r_feet >= w_ply)
                      && (r_feet <= w_ply + 13'(SNAP_TOL));
    assign w_take   = w_hit && (!r_valid || i_plat_y < r_best);
    assign w_nvalid = r_valid | w_take;
    assign w_nbest  = w_take ? i_plat_y : r_best;
    assign w_floor  = r_feet >= 13'(FLOOR_Y);
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? (i_frame_tick ? SCAN : IDLE) :
                 (r_state == SCAN) ? (w_last ? FINISH : SCAN) : IDLE;
    end
    always_comb begin
        o_scan_busy = r_state != IDLE;
        o_scan_done = r_state == FINISH;
        o_plat_addr = (r_state == SCAN && r_cnt != LAST) ? r_cnt[AW-1:0] : '0;
    end
    // The result is registered on the edge into FINISH, folding in the last
    // entry, so it appears together with scan_done and never mid-scan
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt       <= '0;
            r_px        <= '0;
            r_feet      <= '0;
            r_valid     <= 1'b0;
            r_best      <= FLOOR;
            o_on_ground <= 1'b0;
            o_ground_y  <= FLOOR;
        end else begin
            r_cnt <= (r_state == SCAN && !w_last) ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && i_frame_tick) begin
                r_px    <= i_pos_x;
                r_feet  <= {1'b0, i_pos_y} + 13'(CHAR_H);
                r_valid <= 1'b0;
                r_best  <= FLOOR;
            end else if (w_eval) begin
                r_valid <= w_nvalid;
                r_best  <= w_nbest;
            end
            if (w_last) begin
                o_on_ground <= w_nvalid | w_floor;
                o_ground_y  <= w_nvalid ? w_nbest : FLOOR;
            end
        end
    end
endmodule

// File: doc/ground_detect.md
# ground_detect

Per-frame ground/platform collision stage feeding the character controller. Once per video frame it snapshots the character position and scans a platform table held in an external synchronous ROM. It returns whether the character's feet rest on a surface, and the y row of that surface. Its outputs drive the controller's `on_ground` and `ground_y` inputs; its `pos_x`/`pos_y` inputs come from the character block's position outputs.

## Interface
Parameters:
- `NUM_PLAT`, 8: number of platform table entries, ≥2.
- `CHAR_W`, 32: character width in pixels.
- `CHAR_H`, 48: character height in pixels.
- `FLOOR_Y`, 700: screen floor row; always a valid surface.
- `SNAP_TOL`, 4: vertical tolerance below a platform top that still counts as standing on it.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `frame_tick`  in  1: one-cycle pulse per frame; starts a scan.
- `pos_x`  in  12: character top-left x.
- `pos_y`  in  12: character top-left y.
- `plat_addr`  out  $clog2(NUM_PLAT): platform ROM address.
- `plat_x`  in  12: platform left x; valid one cycle after `plat_addr`.
- `plat_y`  in  12: platform top row; valid one cycle after `plat_addr`.
- `plat_w`  in  12: platform width; 0 means the entry is disabled.
- `on_ground`  out  1: the character stands on a surface.
- `ground_y`  out  12: surface row the feet rest on.
- `scan_busy`  out  1: high while a scan is in progress.
- `scan_done`  out  1: one-cycle pulse when the outputs update.

## Operation
- FSM has three states: IDLE, SCAN, FINISH.
- **IDLE**
  - On `frame_tick`, latch `pos_x`/`pos_y` into snapshot registers.
  - Compute `feet = pos_y + CHAR_H` in 13 bits.
  - Clear the candidate (valid=0, best=FLOOR_Y), then go to SCAN.
- **SCAN**
  - Issue `plat_addr` = 0..NUM_PLAT-1 on consecutive cycles.
  - Evaluate each entry the cycle after its address is issued (1-stage pipeline).
  - Leave for FINISH after the last entry is evaluated.
- **Hit test per entry** (all arithmetic 13-bit unsigned, no wrap):
  - `plat_w != 0`, and
  - `pos_x + CHAR_W > plat_x`, and
  - `pos_x < plat_x + plat_w`, and
  - `plat_y <= feet <= plat_y + SNAP_TOL`.
- **Selection**
  - On a hit with `plat_y` < current best, or with no valid candidate yet: best = `plat_y`, valid = 1.
  - Equal `plat_y` from several entries gives the same result; order is irrelevant.
- **Floor rule:** if `feet >= FLOOR_Y` and no platform hit, then valid = 1 and best = FLOOR_Y.
- **FINISH**
  - Register `on_ground` = valid.
  - Register `ground_y` = best if valid, else FLOOR_Y.
  - Pulse `scan_done`, then return to IDLE.
- **Output stability:** `on_ground`/`ground_y` hold their values between FINISH cycles and never show partial scan results.
- **Input isolation:** `pos_x`/`pos_y` changes during a scan do not affect the result, because the scan uses the snapshot.
- **Reset values:**
  - `on_ground` = 0, `ground_y` = FLOOR_Y, `plat_addr` = 0.
  - `scan_busy` = 0, `scan_done` = 0, state IDLE.

## Timing
- Cycle t0: `frame_tick` sampled high in IDLE.
- t0+1 .. t0+NUM_PLAT: `plat_addr` = 0 .. NUM_PLAT-1.
- t0+2 .. t0+NUM_PLAT+1: entries 0 .. NUM_PLAT-1 evaluated.
- t0+NUM_PLAT+2: FINISH. `on_ground`/`ground_y` take their new values and `scan_done` = 1 in this same cycle. Total latency is NUM_PLAT+2 cycles.
- `scan_busy` is high from t0+1 through t0+NUM_PLAT+2 inclusive.
- `plat_addr` returns to 0 in IDLE.
- `frame_tick` while `scan_busy` is ignored; it is neither queued nor allowed to restart the scan.
- `frame_tick` in the FINISH cycle is ignored.
- `rst` asserted mid-scan: the FSM goes to IDLE at once, all outputs take their reset values, and no `scan_done` is issued.

## Test plan
All cases use NUM_PLAT=4, CHAR_W=32, CHAR_H=48, FLOOR_Y=700, SNAP_TOL=4.
- **Reset:** assert `rst`=0 mid-idle → `on_ground`=0, `ground_y`=700, `scan_busy`=0, `scan_done`=0, `plat_addr`=0.
- **Floor:** all `plat_w`=0, `pos_y`=652 (feet 700), pulse `frame_tick` at t0 → at t0+6: `on_ground`=1, `ground_y`=700, `scan_done` pulse. Then `pos_y`=600 → next scan gives `on_ground`=0, `ground_y`=700.
- **Platform hit and edges:** entry1 = (x=100, y=500, w=200), `pos_y`=454 (feet 502).
  - `pos_x`=150 → `on_ground`=1, `ground_y`=500.
  - `pos_x`=68 → miss (right edge 100 not > 100).
  - `pos_x`=69 → hit.
  - `pos_x`=300 → miss.
  - `pos_y`=457 (feet 505) → miss.
- **Priority:** entry0 = (100, 500, 200), entry2 = (120, 498, 100), `pos_x`=150, `pos_y`=452 (feet 500) → entry0 hits, entry2 hits (500 ≤ 502) → `ground_y`=498.
- **Snapshot and ignore:** change `pos_y` and pulse `frame_tick` at t0+3 → result reflects the t0 snapshot, exactly one `scan_done` at t0+6.
- **Reset mid-scan:** assert `rst` at t0+3 → outputs at reset values, no `scan_done`, and the next `frame_tick` runs a full scan normally.
